speech256_axi_ctrl: RTL

- Parametrised AXI4-Lite slave front end for the speech256 synthesiser core.
- Successor to the fixed four-register slave. Adds:
  - configurable scratch-register count;
  - byte-strobe writes;
  - SLVERR decoding for unmapped addresses;
  - an allophone command FIFO that drains to the core over valid/ready;
  - a status register and an optional interrupt.
- Sits between the PS AXI GP port (through the interconnect) and the speech256 core.

---
 rtl/speech256_axi_pkg.sv | 18 +
 rtl/speech256_sym_fifo.sv | 38 +++
 rtl/speech256_axi_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/speech256_axi_pkg.sv
// speech256_axi_pkg: register indices, bit positions, responses and channel states for the speech256 AXI slave
package speech256_axi_pkg;
  localparam int CTRL_IDX = 0;
  localparam int STATUS_IDX = 1;
  localparam int TXDATA_IDX = 2;
  localparam int SCRATCH_BASE = 3;
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_BUSY = 3;
  localparam int ST_LEVEL = 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {CH_IDLE, CH_ACK, CH_RESP} ch_state_t;
endpackage

// File: rtl/speech256_sym_fifo.sv
// speech256_sym_fifo: first-word fall-through allophone FIFO with flush and level
module speech256_sym_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push & ~full & ~flush;
  assign do_pop = pop & ~empty & ~flush;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/speech256_axi_ctrl.sv
// speech256_axi_ctrl: AXI4-Lite slave with scratch regs, status and allophone FIFO; SPEECH256_AXI_IRQ_EN adds the irq output
module speech256_axi_ctrl
  import speech256_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_SCRATCH = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int SYMBOL_WIDTH = 6
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [SYMBOL_WIDTH-1:0]       sym_data,
  output logic                          sym_valid,
  input  logic                          sym_ready,
  input  logic                          core_busy
`ifdef SPEECH256_AXI_IRQ_EN
  ,output logic                         irq
`endif
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int NREG = SCRATCH_BASE + NUM_SCRATCH;
  ch_state_t wstate, rstate;
  logic enable, ovf, full, empty, commit, push, flush, unused;
  logic [LW-1:0] level;
  logic [31:0] scratch [NUM_SCRATCH];
  logic [31:0] wi, ri, rdata_d;
  logic [1:0] wresp, rresp_d;
`ifdef SPEECH256_AXI_IRQ_EN
  logic irq_en;
`endif
  assign wi = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign ri = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign commit = wstate == CH_ACK;
  assign push = commit & (wi == TXDATA_IDX) & S_AXI_WSTRB[0];
  assign flush = commit & (wi == CTRL_IDX) & S_AXI_WSTRB[0] & S_AXI_WDATA[CTRL_FLUSH];
  assign wresp = (wi >= NREG || (push && full)) ? RESP_SLVERR : RESP_OKAY;
  assign sym_valid = enable & ~empty;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  speech256_sym_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SYMBOL_WIDTH)) u_fifo (
    .clk(ACLK),
    .rst(ARESET),
    .push(push),
    .din(S_AXI_WDATA[SYMBOL_WIDTH-1:0]),
    .pop(sym_valid & sym_ready),
    .flush(flush),
    .head(sym_data),
    .full(full),
    .empty(empty),
    .level(level)
  );
  always_comb begin
    rdata_d = '0;
    rresp_d = ri < NREG ? RESP_OKAY : RESP_SLVERR;
    if (ri == CTRL_IDX) begin
      rdata_d[CTRL_ENABLE] = enable;
`ifdef SPEECH256_AXI_IRQ_EN
      rdata_d[CTRL_IRQ_EN] = irq_en;
`endif
    end
    if (ri == STATUS_IDX) begin
      rdata_d[ST_EMPTY] = empty;
      rdata_d[ST_FULL] = full;
      rdata_d[ST_OVF] = ovf;
      rdata_d[ST_BUSY] = core_busy;
      rdata_d[ST_LEVEL +: LW] = level;
    end
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (ri == SCRATCH_BASE + i) rdata_d = scratch[i];
  end
  always_ff @(posedge ACLK)
    if (ARESET) begin
      wstate <= CH_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= RESP_OKAY;
    end else
      case (wstate)
        CH_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
          wstate <= CH_ACK;
          S_AXI_AWREADY <= 1'b1;
          S_AXI_WREADY <= 1'b1;
        end
        CH_ACK: begin
          wstate <= CH_RESP;
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY <= 1'b0;
          S_AXI_BVALID <= 1'b1;
          S_AXI_BRESP <= wresp;
        end
        default: if (S_AXI_BREADY) begin
          wstate <= CH_IDLE;
          S_AXI_BVALID <= 1'b0;
          S_AXI_BRESP <= RESP_OKAY;
        end
      endcase
  always_ff @(posedge ACLK)
    if (ARESET) begin
      rstate <= CH_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else
      case (rstate)
        CH_IDLE: if (S_AXI_ARVALID) begin
          rstate <= CH_ACK;
          S_AXI_ARREADY <= 1'b1;
        end
        CH_ACK: begin
          rstate <= CH_RESP;
          S_AXI_ARREADY <= 1'b0;
          S_AXI_RVALID <= 1'b1;
          S_AXI_RDATA <= rdata_d;
          S_AXI_RRESP <= rresp_d;
        end
        default: if (S_AXI_RREADY) begin
          rstate <= CH_IDLE;
          S_AXI_RVALID <= 1'b0;
          S_AXI_RDATA <= '0;
          S_AXI_RRESP <= RESP_OKAY;
        end
      endcase
  always_ff @(posedge ACLK)
    if (ARESET) begin
      enable <= 1'b0;
      ovf <= 1'b0;
`ifdef SPEECH256_AXI_IRQ_EN
      irq_en <= 1'b0;
`endif
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else begin
      if (commit && wi == CTRL_IDX && S_AXI_WSTRB[0]) begin
        enable <= S_AXI_WDATA[CTRL_ENABLE];
`ifdef SPEECH256_AXI_IRQ_EN
        irq_en <= S_AXI_WDATA[CTRL_IRQ_EN];
`endif
      end
      if (push && full) ovf <= 1'b1;
      else if (commit && wi == STATUS_IDX && S_AXI_WSTRB[0] && S_AXI_WDATA[ST_OVF]) ovf <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (commit && wi == SCRATCH_BASE + i)
          for (int b = 0; b < 4; b++)
            if (S_AXI_WSTRB[b]) scratch[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
    end
`ifdef SPEECH256_AXI_IRQ_EN
  always_ff @(posedge ACLK)
    irq <= ARESET ? 1'b0 : irq_en & ((empty & ~core_busy) | ovf);
`endif
endmodule
